// File: rtl/can_pkg.sv
// Shared CAN receive-path definitions.
//   destuff_state_t : bit destuffer FSM states
//   DOMINANT/RECESSIVE : bus levels
//   DEFAULT_RUN_LEN : equal-bit run length after which a stuff bit follows
package can_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPECT = 2'd2,
        ERR    = 2'd3
    } destuff_state_t;

    localparam logic DOMINANT  = 1'b0;
    localparam logic RECESSIVE = 1'b1;

    localparam int DEFAULT_RUN_LEN = 5;

endpackage

// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer, clocked once per bit at the sample point.
// Removes stuff bits inside the stuffed region, flags stuffing violations
// and counts removed stuff bits per frame.
//
// Ports:
//   SP        - sample-point clock, rising edge
//   reset     - synchronous, active-high
//   RX        - sampled bus bit (0 dominant, 1 recessive)
//   STUFF_EN  - high while inside the stuffed region (SOF..CRC)
//   BIT_OUT   - registered data bit (1 SP latency)
//   BIT_VALID - BIT_OUT is a data bit (low for stuff bits and in error)
//   STF_E     - stuff error, active-low
//   STUFF_CNT - stuff bits removed in the current frame, saturating
//
// RUN_LEN is expected to be at least 2 (a frame start opens a run of one).
module can_bit_destuffer
    import can_pkg::*;
#(
    parameter int RUN_LEN = DEFAULT_RUN_LEN,
    parameter int CNT_W   = 8
) (
    input  logic             SP,
    input  logic             reset,
    input  logic             RX,
    input  logic             STUFF_EN,
    output logic             BIT_OUT,
    output logic             BIT_VALID,
    output logic             STF_E,
    output logic [CNT_W-1:0] STUFF_CNT
);

    localparam int RUN_W = $clog2(RUN_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    destuff_state_t   state;
    logic             last;
    logic [RUN_W-1:0] run;

    always_ff @(posedge SP) begin
        if (reset) begin
            state     <= IDLE;
            last      <= RECESSIVE;
            run       <= '0;
            BIT_OUT   <= RECESSIVE;
            BIT_VALID <= 1'b0;
            STF_E     <= 1'b1;
            STUFF_CNT <= '0;
        end else begin
            // The data bit always mirrors RX; BIT_VALID decides whether it counts.
            BIT_OUT <= RX;
            case (state)
                IDLE: begin
                    BIT_VALID <= 1'b1;
                    if (STUFF_EN) begin
                        last      <= RX;
                        run       <= RUN_ONE;
                        STUFF_CNT <= '0;
                        state     <= RUN;
                    end else begin
                        run <= '0;
                    end
                end

                RUN: begin
                    BIT_VALID <= 1'b1;
                    if (!STUFF_EN) begin
                        run   <= '0;
                        state <= IDLE;
                    end else if (RX == last) begin
                        run <= run + RUN_ONE;
                        if (run + RUN_ONE == RUN_MAX)
                            state <= EXPECT;
                    end else begin
                        last <= RX;
                        run  <= RUN_ONE;
                    end
                end

                // The stuff rule applies here even if STUFF_EN just fell:
                // this is how the stuff bit after the last CRC bit is removed.
                EXPECT: begin
                    BIT_VALID <= 1'b0;
                    if (RX != last) begin
                        if (STUFF_CNT != CNT_MAX)
                            STUFF_CNT <= STUFF_CNT + 1'b1;
                        last  <= RX;
                        run   <= RUN_ONE;   // stuff bit opens the next run
                        state <= STUFF_EN ? RUN : IDLE;
                    end else begin
                        STF_E <= 1'b0;
                        state <= ERR;
                    end
                end

                ERR: begin
                    if (!STUFF_EN) begin
                        STF_E     <= 1'b1;
                        BIT_VALID <= 1'b1;
                        run       <= '0;
                        state     <= IDLE;
                    end else begin
                        STF_E     <= 1'b0;
                        BIT_VALID <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Randomized and directed bench for can_bit_destuffer.
// Two instances run in lockstep: default widths, and CNT_W=2 to reach
// counter saturation. A queue-based reference model derives expected
// outputs from the stuffing rules directly.
module tb_can_bit_destuffer;

    localparam int RUN_LEN = 5;

    logic       SP = 1'b0;
    logic       reset = 1'b0;
    logic       RX = 1'b1;
    logic       STUFF_EN = 1'b0;

    logic       d_out, d_vld, d_stf;
    logic [7:0] d_cnt;
    logic       s_out, s_vld, s_stf;
    logic [1:0] s_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    can_bit_destuffer #(.RUN_LEN(RUN_LEN), .CNT_W(8)) u_dut (
        .SP(SP), .reset(reset), .RX(RX), .STUFF_EN(STUFF_EN),
        .BIT_OUT(d_out), .BIT_VALID(d_vld), .STF_E(d_stf), .STUFF_CNT(d_cnt)
    );

    can_bit_destuffer #(.RUN_LEN(RUN_LEN), .CNT_W(2)) u_sat (
        .SP(SP), .reset(reset), .RX(RX), .STUFF_EN(STUFF_EN),
        .BIT_OUT(s_out), .BIT_VALID(s_vld), .STF_E(s_stf), .STUFF_CNT(s_cnt)
    );

    always #5 SP = ~SP;

    // Reference model: frame bits since the last run break kept in a queue.
    bit      m_inframe = 0;
    bit      m_err     = 0;
    bit      hist[$];
    logic    e_out = 1'b1, e_vld = 1'b0, e_stf = 1'b1;
    int      e_cnt = 0;   // unbounded; each instance saturates at its own max

    function automatic int trail();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model(input bit rst, input bit rx, input bit en);
        if (rst) begin
            e_out = 1'b1; e_vld = 1'b0; e_stf = 1'b1; e_cnt = 0;
            m_inframe = 0; m_err = 0; hist.delete();
            return;
        end
        e_out = rx;
        if (m_err) begin
            if (!en) begin m_err = 0; e_stf = 1'b1; e_vld = 1'b1; end
            else     begin e_stf = 1'b0; e_vld = 1'b0; end
            return;
        end
        if (m_inframe && hist.size() > 0 && trail() == RUN_LEN) begin
            e_vld = 1'b0;
            if (rx != hist[hist.size() - 1]) begin
                e_cnt++;
                hist.delete();
                hist.push_back(rx);
                if (!en) begin m_inframe = 0; hist.delete(); end
            end else begin
                m_err = 1; m_inframe = 0; e_stf = 1'b0; hist.delete();
            end
            return;
        end
        e_vld = 1'b1;
        if (!en) begin
            m_inframe = 0; hist.delete();
        end else if (!m_inframe) begin
            m_inframe = 1; e_cnt = 0; hist.delete(); hist.push_back(rx);
        end else begin
            hist.push_back(rx);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Drive one bit, clock it, then compare both instances with the model.
    task automatic step(input bit rst, input bit rx, input bit en);
        reset = rst; RX = rx; STUFF_EN = en;
        @(posedge SP);
        #1;
        model(rst, rx, en);
        chk("bit_out",   {31'd0, d_out}, {31'd0, e_out});
        chk("bit_valid", {31'd0, d_vld}, {31'd0, e_vld});
        chk("stf_e",     {31'd0, d_stf}, {31'd0, e_stf});
        chk("cnt8",      {24'd0, d_cnt}, (e_cnt > 255) ? 32'd255 : 32'(e_cnt));
        chk("cnt2",      {30'd0, s_cnt}, (e_cnt > 3) ? 32'd3 : 32'(e_cnt));
        chk("sat_vld",   {31'd0, s_vld}, {31'd0, e_vld});
        chk("sat_stf",   {31'd0, s_stf}, {31'd0, e_stf});
    endtask

    initial begin
        bit prev;
        bit pat [];

        // Reset with arbitrary RX
        step(1, 1'b0, 1'b1);
        chk("rst_out", {31'd0, d_out}, 32'd1);
        chk("rst_vld", {31'd0, d_vld}, 32'd0);
        chk("rst_stf", {31'd0, d_stf}, 32'd1);
        chk("rst_cnt", {24'd0, d_cnt}, 32'd0);
        step(0, 1'b1, 1'b0);

        // Normal destuff: 0,0,0,0,0,1(stuff),0,1
        pat = '{0, 0, 0, 0, 0, 1, 0, 1};
        foreach (pat[i]) begin
            step(0, pat[i], 1'b1);
            if (i == 5) begin
                chk("dstf_vld", {31'd0, d_vld}, 32'd0);
                chk("dstf_cnt", {24'd0, d_cnt}, 32'd1);
            end else begin
                chk("data_vld", {31'd0, d_vld}, 32'd1);
            end
            chk("dstf_stf", {31'd0, d_stf}, 32'd1);
        end
        step(0, 1'b1, 1'b0);

        // Stuff error: six 1s, held three more bits, released by STUFF_EN=0
        for (int i = 0; i < 6; i++) step(0, 1'b1, 1'b1);
        chk("err_raise", {31'd0, d_stf}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, i[0], 1'b1);
            chk("err_hold", {31'd0, d_stf}, 32'd0);
        end
        step(0, 1'b1, 1'b0);
        chk("err_clear", {31'd0, d_stf}, 32'd1);
        chk("err_pass",  {31'd0, d_vld}, 32'd1);

        // Stuff bit after last CRC bit
        for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1);
        step(0, 1'b1, 1'b0);
        chk("crc_stuff_vld", {31'd0, d_vld}, 32'd0);
        chk("crc_stuff_cnt", {24'd0, d_cnt}, 32'd1);
        step(0, 1'b1, 1'b0);
        chk("crc_after_vld", {31'd0, d_vld}, 32'd1);

        // No-stuff alternating pattern
        for (int i = 0; i < 20; i++) step(0, ~i[0], 1'b1);
        chk("alt_cnt", {24'd0, d_cnt}, 32'd0);
        step(0, 1'b1, 1'b0);

        // Reset mid-run, then four more 0s must not expect a stuff bit
        for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1);
        step(1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1);
        step(0, 1'b1, 1'b1);
        chk("rst_mid_vld", {31'd0, d_vld}, 32'd1);
        chk("rst_mid_stf", {31'd0, d_stf}, 32'd1);
        step(0, 1'b1, 1'b0);

        // Four stuff bits in one frame: CNT_W=2 instance saturates at 3
        pat = '{0,0,0,0,0, 1, 1,1,1,1, 0, 0,0,0,0, 1, 1,1,1,1, 0};
        foreach (pat[i]) step(0, pat[i], 1'b1);
        chk("sat_cnt2", {30'd0, s_cnt}, 32'd3);
        chk("sat_cnt8", {24'd0, d_cnt}, 32'd4);
        step(0, 1'b1, 1'b0);
        chk("cnt_hold", {24'd0, d_cnt}, 32'd4);

        // Random frames with biased runs so stuff bits and errors occur
        prev = 1'b1;
        for (int f = 0; f < 200; f++) begin
            int gap = $urandom_range(1, 3);
            int len = $urandom_range(5, 40);
            for (int g = 0; g < gap; g++) step(0, 1'($urandom_range(0, 1)), 1'b0);
            for (int b = 0; b < len; b++) begin
                bit rx = ($urandom_range(0, 99) < 75) ? prev : ~prev;
                bit rst = ($urandom_range(0, 199) == 0);
                step(rst, rx, 1'b1);
                prev = rx;
            end
        end
        step(0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", n_chk);
        $fatal(1);
    end

endmodule

// File: doc/can_bit_destuffer.md
# can_bit_destuffer

- Receive-path stage directly upstream of the CAN error checker.
- Clocked once per bit at the sample point. Takes each sampled bus bit, removes stuff bits inside the stuffed region (SOF through CRC), and forwards the remaining bits with a valid flag.
- Detects violations of the stuffing rule and drives the active-low `STF_E` flag consumed by the error checker, which samples it on the same `SP` edge.
- Counts stuff bits removed per frame for debug and statistics.

## Interface
Parameters:
- `RUN_LEN`, default 5: number of equal consecutive bits after which a stuff bit is mandatory.
- `CNT_W`, default 8: width of the stuff-bit counter.

Ports (one clock; reset is synchronous and active-high):
- `SP` input 1: sample-point clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high; highest priority.
- `RX` input 1: sampled bus bit (0 = dominant, 1 = recessive).
- `STUFF_EN` input 1: high while the frame decoder is inside the stuffed region.
- `BIT_OUT` output 1: registered data bit.
- `BIT_VALID` output 1: high when `BIT_OUT` is a data bit; low for removed stuff bits and while in error.
- `STF_E` output 1: stuff error, active-low (0 = error).
- `STUFF_CNT` output `CNT_W`: stuff bits removed in the current frame; saturating.

## Operation
- Internal state: `last` (previous bit), `run` (length of the current equal run, 0..`RUN_LEN`), and FSM `state`.
- FSM states:
  - **IDLE**
    - `STUFF_EN`=0: pass-through. `BIT_OUT`=`RX`, `BIT_VALID`=1, `run`=0.
    - `STUFF_EN`=1: start of frame. `last`=`RX`, `run`=1, `STUFF_CNT`=0, bit forwarded valid, go to RUN.
  - **RUN**
    - `STUFF_EN`=0: go to IDLE; this bit is handled as in IDLE.
    - `RX`==`last`: `run`+1. When the new run equals `RUN_LEN`, go to EXPECT. Bit forwarded valid.
    - `RX`!=`last`: `last`=`RX`, `run`=1. Bit forwarded valid.
  - **EXPECT**: the current bit is a stuff bit regardless of `STUFF_EN`. This covers the stuff bit that follows the last CRC bit.
    - `RX`!=`last`: stuff bit. `BIT_VALID`=0, `STUFF_CNT`+1 (saturating at 2^`CNT_W`−1), `last`=`RX`, `run`=1.
      - Go to RUN if `STUFF_EN`=1, otherwise go to IDLE.
      - The stuff bit counts as the first bit of the next run.
    - `RX`==`last`: stuff error. `STF_E`=0, `BIT_VALID`=0, go to ERR.
  - **ERR**
    - `STF_E` is held 0 and `BIT_VALID` is held 0.
    - On the first edge with `STUFF_EN`=0: `STF_E`=1, go to IDLE (pass-through for that bit).
- `STUFF_CNT` holds its value after the frame until the next IDLE→RUN transition.

## Timing
- All outputs are registered. The values produced from `RX` sampled at edge k are visible after edge k and remain stable until edge k+1. Latency is 1 `SP`.
- Reset values: state IDLE, `BIT_OUT`=1, `BIT_VALID`=0, `STF_E`=1, `STUFF_CNT`=0, `run`=0, `last`=1.
- Reset asserted mid-frame, in any state: all of the above apply at that edge. The first edge after release is evaluated as IDLE.
- If `reset` and `STUFF_EN` are both high on the same edge, reset wins and no frame start is recorded.
- The error is raised exactly on the bit at position `RUN_LEN`+1 of an equal run. A run of exactly `RUN_LEN` never raises an error on its own.
- If `STUFF_EN` falls on the same edge as an EXPECT bit, the stuff rule is still applied to that bit.

## Structure
- Shared package `can_pkg` holds:
  - enum `destuff_state_t` {IDLE, RUN, EXPECT, ERR}
  - constants `DOMINANT`=1'b0, `RECESSIVE`=1'b1
  - default `RUN_LEN`
- Single flat module. The run and stuff counters are inline, so no sub-module is needed.

## Test plan
- **Reset:** pulse `reset` with arbitrary `RX` → `BIT_OUT`=1, `BIT_VALID`=0, `STF_E`=1, `STUFF_CNT`=0.
- **Normal destuff:** `STUFF_EN`=1, `RX`=0,0,0,0,0,1,0,1 → first five bits valid; the 1 has `BIT_VALID`=0 and `STUFF_CNT`=1; the following 0 and 1 are valid; `STF_E` stays 1.
- **Stuff error:** `STUFF_EN`=1, `RX`=1×6 → `STF_E`=0 after the 6th edge and held for 3 more bits; drop `STUFF_EN` → `STF_E`=1 after the next edge.
- **Stuff bit after last CRC bit:** five 0s, then `STUFF_EN` falls on the same edge as `RX`=1 → that bit has `BIT_VALID`=0 and `STUFF_CNT` increments; the next bit passes through valid.
- **No-stuff pattern:** `STUFF_EN`=1, `RX` alternating 1,0 for 20 bits → all bits valid, `STUFF_CNT`=0.
- **Reset mid-run and saturation:**
  - Reset after four 0s, then release with `STUFF_EN`=1 and four more 0s → no stuff expectation and no error.
  - With `CNT_W`=2, four valid stuff bits in one frame → `STUFF_CNT`=3.
